lsu_mem_ctrl: RTL

Load/store sequencer between the execute stage and the single-ported data memory.
- Accepts one memory op per handshake.
- Drives the memory request with lane-aligned byte enables and data, and waits a variable number of cycles for ack.
- Extends load data per funct3 and produces the register-file writeback pulse (wb_en/wb_reg/wb_val).
- Keeps the pipeline stalled (busy) while an op is outstanding.

---
 rtl/lsu_mem_ctrl_if.sv | 38 +++
 rtl/lsu_mem_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Execute-stage request, data-memory bus and writeback signals of the load/store sequencer.
// slave = the sequencer; master = the execute stage and memory around it.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_val;

    logic        busy;
    logic        bus_err;

    modport slave (
        input  req_valid, req_we, req_f3, req_addr, req_wdata, req_rd, mem_ack, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               wb_en, wb_reg, wb_val, busy, bus_err
    );

    modport master (
        output req_valid, req_we, req_f3, req_addr, req_wdata, req_rd, mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               wb_en, wb_reg, wb_val, busy, bus_err
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between execute and a single-ported data memory, with ack timeout.
// Optional MISALIGN_TRAP_EN: misaligned half/word ops skip memory and pulse the misalign output.
module lsu_mem_ctrl #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    lsu_mem_ctrl_if.slave      bus
`ifdef MISALIGN_TRAP_EN
    ,
    output logic               misalign
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             op_we;
    logic [2:0]       op_f3;
    logic [1:0]       op_lo;
    logic [4:0]       op_rd;

    logic f3_illegal;
    logic timeout;
`ifdef MISALIGN_TRAP_EN
    logic addr_misaligned;
`endif

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   byte_en = 4'b0001 << lo;
            2'b01:   byte_en = lo[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3[1:0])
            2'b00:   store_data = {4{wdata[7:0]}};
            2'b01:   store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] rdata);
        logic [31:0] b;
        logic [31:0] h;
        b = rdata >> {lo, 3'b000};
        h = rdata >> {lo[1], 4'b0000};
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b[7:0]};
            3'b001:  load_ext = {{16{h[15]}}, h[15:0]};
            3'b100:  load_ext = {24'h0, b[7:0]};
            3'b101:  load_ext = {16'h0, h[15:0]};
            default: load_ext = rdata;
        endcase
    endfunction

    // Stores only have byte/half/word; loads additionally have the unsigned byte/half forms.
    assign f3_illegal = bus.req_we ? (bus.req_f3[2] || bus.req_f3[1:0] == 2'b11)
                                   : (bus.req_f3 == 3'b011 || bus.req_f3[2:1] == 2'b11);
    assign timeout    = (MAX_WAIT != 0) && (wait_cnt == LAST_CNT);
`ifdef MISALIGN_TRAP_EN
    assign addr_misaligned = (bus.req_f3[1:0] == 2'b01 && bus.req_addr[0]) ||
                             (bus.req_f3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`endif

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);

    // NOTE: all state and registered outputs use non-blocking assignment so every read
    // in this block sees the pre-edge value, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            op_we         <= 1'b0;
            op_f3         <= 3'b000;
            op_lo         <= 2'b00;
            op_rd         <= 5'd0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.mem_be    <= 4'h0;
            bus.mem_wdata <= 32'h0;
            bus.wb_en     <= 1'b0;
            bus.wb_reg    <= 5'd0;
            bus.wb_val    <= 32'h0;
            bus.bus_err   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign      <= 1'b0;
`endif
        end else begin
            bus.wb_en   <= 1'b0;
            bus.bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_we    <= bus.req_we;
                        op_f3    <= bus.req_f3;
                        op_lo    <= bus.req_addr[1:0];
                        op_rd    <= bus.req_rd;
                        wait_cnt <= '0;
                        if (f3_illegal) begin
                            state      <= DONE;
                            bus.wb_en  <= !bus.req_we && (bus.req_rd != 5'd0);
                            bus.wb_reg <= bus.req_rd;
                            bus.wb_val <= 32'h0;
`ifdef MISALIGN_TRAP_EN
                        end else if (addr_misaligned) begin
                            state    <= DONE;
                            misalign <= 1'b1;
`endif
                        end else begin
                            state         <= ACCESS;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.req_we;
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_be    <= byte_en(bus.req_f3, bus.req_addr[1:0]);
                            bus.mem_wdata <= store_data(bus.req_f3, bus.req_wdata);
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ack) begin
                        state       <= DONE;
                        bus.mem_req <= 1'b0;
                        if (!op_we) begin
                            bus.wb_en  <= (op_rd != 5'd0);
                            bus.wb_reg <= op_rd;
                            bus.wb_val <= load_ext(op_f3, op_lo, bus.mem_rdata);
                        end
                    end else if (timeout) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                        bus.bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
